// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: receiver state
// encoding, parity mode constants and bit-timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_BREAK  = 3'd6
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit; integer division, the remainder is dropped.
  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of a counter that must hold 0..ticks-1.
  function automatic int cnt_width(input int ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Clearable bit-period tick counter with half-bit and sample-point strobes.
// Shared between the UART receiver and the future transmitter.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 434,
  localparam int CNT_W = cnt_width(BIT_TICKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             half_tick,
  output logic             sample_tick
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_TICKS - 1);

  assign half_tick   = (cnt == HALF_CNT);
  assign sample_tick = (cnt == LAST_CNT);

  // Count 0..BIT_TICKS-1 and wrap; a clear restarts the bit period at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (sample_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable baud ratio, data width, parity
// and stop-bit count, with separate frame and parity error pulses.
// Build option UART_RX_MAJORITY_EN: data, parity and stop bits are decided
// by a 2-of-3 vote over the last three cycles of each bit period instead of
// a single sample.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_raw,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int BIT_TICKS = bit_ticks(CLK_FREQ, BAUD);
  localparam int CNT_W     = cnt_width(BIT_TICKS);
  localparam int IDX_W     = $clog2(DATA_BITS + 1);

  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rx;
  uart_state_e          state;
  uart_state_e          state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 half_tick;
  logic                 sample_tick;
  logic                 cnt_clr;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 bit_val;

  // Mismatch between received data+parity and the configured parity mode.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                           input logic p);
    logic x;
    x = ^d ^ p;
    if (PARITY == PAR_ODD) begin
      return ~x;
    end else if (PARITY == PAR_EVEN) begin
      return x;
    end
    return 1'b0;
  endfunction

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= rx_raw;
      rx      <= rx_meta;
    end
  end

  // Every state change restarts the bit period.
  assign cnt_clr = (state_next != state);

  uart_baud_counter #(
    .BIT_TICKS(BIT_TICKS)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .cnt        (cnt),
    .half_tick  (half_tick),
    .sample_tick(sample_tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] VOTE_A_CNT = CNT_W'(BIT_TICKS - 3);
  localparam logic [CNT_W-1:0] VOTE_B_CNT = CNT_W'(BIT_TICKS - 2);

  logic vote_a;
  logic vote_b;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two earlier votes; the third is rx at the sample point itself.
  always_ff @(posedge clk) begin
    if (cnt == VOTE_A_CNT) vote_a <= rx;
    if (cnt == VOTE_B_CNT) vote_b <= rx;
  end

  assign bit_val = majority3(vote_a, vote_b, rx);
`else
  // Without the voter the counter value itself is not needed here.
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign bit_val    = rx;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; decisions happen only on counter strobes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!rx) state_next = ST_START;
      end
      ST_START: begin
        // Mid-start-bit recheck rejects short glitches silently.
        if (half_tick) state_next = rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_tick && (bit_idx == LAST_BIT)) begin
          state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (sample_tick) begin
          if (!bit_val) begin
            state_next = ST_BREAK;
          end else if (bit_idx == LAST_STOP) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_BREAK: begin
        // A line held low reports once, then waits for it to release.
        if (rx) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Bit index, LSB-first shift register and captured parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (cnt_clr) begin
        bit_idx <= '0;
      end else if (sample_tick && (state == ST_DATA || state == ST_STOP)) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == ST_DATA && sample_tick) begin
        shift <= {bit_val, shift[DATA_BITS-1:1]};
      end
      if (state == ST_PARITY && sample_tick) begin
        par_bit <= bit_val;
      end
    end
  end

  // Output pulses; data and parity status land together in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      data_valid   <= (state_next == ST_DONE);
      parity_error <= (state_next == ST_DONE) && parity_mismatch(shift, par_bit);
      frame_error  <= (state == ST_STOP) && sample_tick && !bit_val;
      if (state_next == ST_DONE) begin
        data_out <= shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised bench for uart_rx_cfg: four configurations side by side, each
// with its own serial line, checked against a waveform-level reference that
// reads every bit at the middle of its bit period.
module tb_uart_rx_cfg;

`ifdef UART_RX_MAJORITY_EN
  localparam int GLITCH_BACK = 1;
`else
  localparam int GLITCH_BACK = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx_line [4];
  logic dv [4];
  logic fe [4];
  logic pe [4];
  logic bsy [4];
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  logic [8:0] d3;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int dv_cyc [4];
  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg u_def (
    .clk(clk), .rst(rst), .rx_raw(rx_line[0]), .data_out(d0),
    .data_valid(dv[0]), .frame_error(fe[0]), .parity_error(pe[0]), .busy(bsy[0]));

  uart_rx_cfg #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_par (
    .clk(clk), .rst(rst), .rx_raw(rx_line[1]), .data_out(d1),
    .data_valid(dv[1]), .frame_error(fe[1]), .parity_error(pe[1]), .busy(bsy[1]));

  uart_rx_cfg #(.CLK_FREQ(192000), .BAUD(9600), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_b7 (
    .clk(clk), .rst(rst), .rx_raw(rx_line[2]), .data_out(d2),
    .data_valid(dv[2]), .frame_error(fe[2]), .parity_error(pe[2]), .busy(bsy[2]));

  uart_rx_cfg #(.CLK_FREQ(1200), .BAUD(100), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .rx_raw(rx_line[3]), .data_out(d3),
    .data_valid(dv[3]), .frame_error(fe[3]), .parity_error(pe[3]), .busy(bsy[3]));

  function automatic int cfg_bt(input int s);
    case (s)
      0: return 50000000 / 115200;
      1: return 1600 / 100;
      2: return 192000 / 9600;
      default: return 1200 / 100;
    endcase
  endfunction
  function automatic int cfg_db(input int s);
    case (s) 0: return 8; 1: return 8; 2: return 7; default: return 9; endcase
  endfunction
  function automatic int cfg_pm(input int s);
    case (s) 0: return 0; 1: return 2; 2: return 0; default: return 1; endcase
  endfunction
  function automatic int cfg_sb(input int s);
    case (s) 0: return 2; 1: return 1; 2: return 2; default: return 1; endcase
  endfunction

  function automatic logic [8:0] dout_of(input int k);
    case (k)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {2'b00, d2};
      default: return d3;
    endcase
  endfunction

  // Every output pulse becomes one event {instance, dv, fe, pe, data}.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dv[k] === 1'b1 || fe[k] === 1'b1 || pe[k] === 1'b1) begin
        got_q.push_back({k[1:0], dv[k], fe[k], pe[k], (dv[k] === 1'b1) ? dout_of(k) : 9'h000});
        if (dv[k] === 1'b1) dv_cyc[k] = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_event"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Line level the receiver settles on for the bit centred at p.
  function automatic bit seen(input bit w[$], input int p);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(w[p-2]) + int'(w[p-1]) + int'(w[p]);
    return ones >= 2;
`else
    return w[p];
`endif
  endfunction

  // Build a frame waveform, predict its outcome, then drive it cycle by cycle.
  // ncyc > 0 drives only a prefix and predicts nothing.
  task automatic send_frame(input int s, input logic [8:0] data, input bit par_flip,
                            input int bad_stop, input int glitch_bit, input int ncyc,
                            output int c0);
    int bt, db, pm, sb, np, pos, len;
    bit lv[$];
    bit w[$];
    bit p, x, pe_exp, fe_exp;
    logic [8:0] d_exp;
    bt = cfg_bt(s);
    db = cfg_db(s);
    pm = cfg_pm(s);
    sb = cfg_sb(s);
    np = (pm != 0) ? 1 : 0;
    lv.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      lv.push_back(data[i]);
      p ^= data[i];
    end
    if (pm == 1) lv.push_back(~p ^ par_flip);
    else if (pm == 2) lv.push_back(p ^ par_flip);
    for (int j = 0; j < sb; j++) lv.push_back(j != bad_stop);
    for (int j = 0; j < lv.size(); j++) begin
      for (int c = 0; c < bt; c++) w.push_back(lv[j]);
    end
    if (glitch_bit >= 0) begin
      pos = glitch_bit * bt + bt / 2 - GLITCH_BACK;
      w[pos] = ~w[pos];
    end
    if (ncyc == 0) begin
      d_exp = 9'h000;
      x = 1'b0;
      fe_exp = 1'b0;
      for (int i = 0; i < db; i++) begin
        d_exp[i] = seen(w, (i + 1) * bt + bt / 2);
        x ^= d_exp[i];
      end
      if (np != 0) x ^= seen(w, (db + 1) * bt + bt / 2);
      for (int j = 0; j < sb; j++) begin
        if (!seen(w, (db + 1 + np + j) * bt + bt / 2)) fe_exp = 1'b1;
      end
      pe_exp = (pm == 1) ? !x : (pm == 2) ? x : 1'b0;
      if (fe_exp) exp_q.push_back({s[1:0], 1'b0, 1'b1, 1'b0, 9'h000});
      else exp_q.push_back({s[1:0], 1'b1, 1'b0, pe_exp, d_exp});
    end
    len = (ncyc == 0) ? w.size() : ncyc;
    c0 = cyc;
    for (int c = 0; c < len; c++) begin
      rx_line[s] = w[c];
      @(posedge clk);
      #1;
    end
    rx_line[s] = 1'b1;
  endtask

  initial begin
    int c0, bt, busy_cnt, bs;
    for (int k = 0; k < 4; k++) rx_line[k] = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", d0, 8'h00);
    check("rst_valid", dv[0], 1'b0);
    check("rst_frame_err", fe[0], 1'b0);
    check("rst_parity_err", pe[0], 1'b0);
    check("rst_busy", bsy[0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // Default 8N2 at 434 cycles per bit.
    bt = cfg_bt(0);
    send_frame(0, 9'h0A5, 1'b0, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("a5");
    check("a5_data_out", d0, 8'hA5);
    // Middle of the second stop bit, two synchroniser stages, one cycle to the pulse.
    check("a5_latency", dv_cyc[0] - c0, (10 * bt + bt / 2) + 2 + 1);

    send_frame(0, 9'h05A, 1'b0, 1, -1, 0, c0);
    idle(2 * bt);
    check_events("stop2_low");
    check("stop2_hold_data", d0, 8'hA5);

    rx_line[0] = 1'b0;
    idle(20 * bt);
    rx_line[0] = 1'b1;
    idle(2 * bt);
    exp_q.push_back({2'd0, 1'b0, 1'b1, 1'b0, 9'h000});
    check_events("break");
    send_frame(0, 9'h011, 1'b0, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("after_break");
    check("after_break_data", d0, 8'h11);

    // 100-cycle low glitch: the mid-start recheck rejects it.
    busy_cnt = 0;
    rx_line[0] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bsy[0] === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      if (k == 99) rx_line[0] = 1'b1;
    end
    check("glitch_busy_cycles", busy_cnt, bt / 2);
    check_events("glitch");

    // Reset in the middle of the data bits.
    send_frame(0, 9'h03C, 1'b0, -1, -1, 3 * bt, c0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_data_out", d0, 8'h00);
    check("midrst_valid", dv[0], 1'b0);
    check("midrst_frame_err", fe[0], 1'b0);
    check("midrst_parity_err", pe[0], 1'b0);
    check("midrst_busy", bsy[0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * bt);
    check_events("midrst");
    send_frame(0, 9'h0C3, 1'b0, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("c3");
    check("c3_data_out", d0, 8'hC3);

    // Even parity, one stop bit.
    bt = cfg_bt(1);
    send_frame(1, 9'h003, 1'b1, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("par_wrong");
    send_frame(1, 9'h003, 1'b0, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("par_right");
    for (int n = 0; n < 30; n++) begin
      bs = ($urandom_range(0, 7) == 0) ? 0 : -1;
      send_frame(1, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), bs, -1, 0, c0);
      idle((bs >= 0) ? 2 * bt : $urandom_range(0, bt));
    end
    idle(2 * bt);
    check_events("par_random");

    // 7 data bits, back-to-back frames with no idle gap.
    bt = cfg_bt(2);
    send_frame(2, 9'h07F, 1'b0, -1, -1, 0, c0);
    send_frame(2, 9'h000, 1'b0, -1, -1, 0, c0);
    idle(2 * bt);
    check_events("b2b");
    send_frame(2, 9'h055, 1'b0, -1, 4, 0, c0);
    idle(2 * bt);
    check_events("glitch_bit3");
`ifdef UART_RX_MAJORITY_EN
    check("glitch_bit3_data", d2, 7'h55);
`else
    check("glitch_bit3_data", d2, 7'h5D);
`endif
    for (int n = 0; n < 12; n++) begin
      send_frame(2, 9'($urandom_range(0, 127)), 1'b0, -1, -1, 0, c0);
    end
    idle(2 * bt);
    check_events("b7_random");

    // 9 data bits, odd parity, one stop bit.
    bt = cfg_bt(3);
    for (int n = 0; n < 30; n++) begin
      bs = ($urandom_range(0, 7) == 0) ? 0 : -1;
      send_frame(3, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), bs, -1, 0, c0);
      idle((bs >= 0) ? 2 * bt : $urandom_range(0, bt));
    end
    idle(2 * bt);
    check_events("odd_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
